// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Arbitrates MEM exceptions, EX multi-cycle ops, ID load-use stalls and ID branches.
module pipe_ctrl #(
  parameter int          CNT_W      = 5,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             branch_flag_id,
  input  logic [31:0]      branch_addr_id,
  input  logic             exc_mem,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             flush_if_id,
  output logic             pc_redirect,
  output logic [31:0]      new_pc,
  output logic             ex_mc_done,
  output logic [31:0]      stall_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    EX_BUSY,
    EXC_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] busy_q, busy_d;
  logic [31:0]      cnt_q;
  logic             low_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (|stall)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cycles = cnt_q;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    stall       = '0;
    flush       = 1'b0;
    flush_if_id = 1'b0;
    pc_redirect = 1'b0;
    new_pc      = '0;
    ex_mc_done  = 1'b0;
    low_ok      = 1'b0;
    if (rst) begin
      state_d = IDLE;
      busy_d  = '0;
    end else if (state_q == EXC_FLUSH) begin
      flush   = 1'b1;
      state_d = IDLE;
    end else if (exc_mem) begin
      flush       = 1'b1;
      pc_redirect = 1'b1;
      new_pc      = EXC_VECTOR;
      busy_d      = '0;
      state_d     = EXC_FLUSH;
    end else begin
      low_ok = 1'b1;
      if (state_q == EX_BUSY) begin
        if (busy_q == '0) begin
          ex_mc_done = 1'b1;
          state_d    = IDLE;
        end else begin
          stall  = 6'b001111;
          busy_d = busy_q - CNT_W'(1);
          low_ok = 1'b0;
        end
      end else if (ex_mc_start) begin
        if (ex_mc_cycles <= CNT_W'(1)) begin
          ex_mc_done = 1'b1;
        end else begin
          stall   = 6'b001111;
          busy_d  = ex_mc_cycles - CNT_W'(2);
          state_d = EX_BUSY;
          low_ok  = 1'b0;
        end
      end
      // a branch only redirects when nothing holds the front end
      if (low_ok) begin
        if (stallreq_id) begin
          stall = 6'b000111;
        end else if (branch_flag_id) begin
          pc_redirect = 1'b1;
          new_pc      = branch_addr_id;
          flush_if_id = 1'b1;
        end
      end
    end
  end

endmodule
